nested_object_buffer: RTL and testbench

NESTED_OBJECT_BUFFER -- requirements
Module: nested_object_buffer

---
 rtl/nested_object_buffer.sv | 120 ++++++++++++
 tb/tb_nested_object_buffer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nested_object_buffer.sv
// FIFO of table entries for a serializer, tagged on the way out with the C++ object
// address each entry belongs to, tracked by a stack of nested-object base pointers.
module nested_object_buffer #(
  parameter int DEPTH       = 64,
  parameter int ENTRY_W     = 128,
  parameter int ADDR_W      = 64,
  parameter int STACK_DEPTH = 16,
  localparam int PTR_W      = $clog2(DEPTH),
  localparam int CNT_W      = PTR_W + 1,
  localparam int SP_W       = $clog2(STACK_DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ENTRY_W-1:0] in_entry,
  input  logic               in_nested,
  input  logic               in_end_obj,
  input  logic [ADDR_W-1:0]  in_offset,
  input  logic [ADDR_W-1:0]  base_addr_in,
  input  logic               base_addr_load,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ENTRY_W-1:0] out_entry,
  output logic [ADDR_W-1:0]  out_base_addr,
  output logic [SP_W-1:0]    out_depth,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty,
  output logic               stack_overflow,
  output logic               stack_underflow
);

  localparam logic [SP_W-1:0]  SP_MAX   = SP_W'(STACK_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [ENTRY_W-1:0] mem_entry  [DEPTH];
  logic               mem_nested [DEPTH];
  logic               mem_end    [DEPTH];
  logic [ADDR_W-1:0]  mem_offset [DEPTH];

  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;

  logic [ADDR_W-1:0]  stack [STACK_DEPTH];
  logic [SP_W-1:0]    sp;

  logic push;
  logic pop;
  logic head_nested;
  logic head_end;

  assign full      = (count == CNT_FULL);
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_entry     = mem_entry[head];
  assign head_nested   = mem_nested[head];
  // An entry flagged both nested and end_obj only opens a child object.
  assign head_end      = mem_end[head] && !mem_nested[head];
  assign out_base_addr = stack[sp];
  assign out_depth     = sp;

  // Slot payload storage: written on push only, never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_entry[tail]  <= in_entry;
      mem_nested[tail] <= in_nested;
      mem_end[tail]    <= in_end_obj;
      mem_offset[tail] <= in_offset;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Stack moves after the head entry has been delivered, so a nested entry is
  // reported with its parent address and an end_obj entry with its child address.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp              <= '0;
      stack[0]        <= '0;
      stack_overflow  <= 1'b0;
      stack_underflow <= 1'b0;
    end else if (base_addr_load) begin
      stack[0] <= base_addr_in;
      sp       <= '0;
    end else if (pop && head_nested) begin
      if (sp == SP_MAX) begin
        stack_overflow <= 1'b1;
      end else begin
        sp                    <= sp + SP_W'(1);
        stack[sp + SP_W'(1)]  <= stack[sp] + mem_offset[head];
      end
    end else if (pop && head_end) begin
      if (sp == '0) begin
        stack_underflow <= 1'b1;
      end else begin
        sp <= sp - SP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_nested_object_buffer.sv
// Scoreboarded bench for nested_object_buffer with DEPTH=4, STACK_DEPTH=2 so the
// full/wrap and stack overflow/underflow corners are reachable with short vectors.
module tb_nested_object_buffer;

  localparam int DEPTH = 4;
  localparam int ENTRY_W = 16;
  localparam int ADDR_W = 32;
  localparam int STACK_DEPTH = 2;

  typedef struct {
    logic [ENTRY_W-1:0] entry;
    logic [ADDR_W-1:0]  base;
    logic [0:0]         depth;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [ENTRY_W-1:0] in_entry;
  logic               in_nested;
  logic               in_end_obj;
  logic [ADDR_W-1:0]  in_offset;
  logic [ADDR_W-1:0]  base_addr_in;
  logic               base_addr_load;
  logic               out_valid;
  logic               out_ready;
  logic [ENTRY_W-1:0] out_entry;
  logic [ADDR_W-1:0]  out_base_addr;
  logic [0:0]         out_depth;
  logic [2:0]         count;
  logic               full;
  logic               empty;
  logic               stack_overflow;
  logic               stack_underflow;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  nested_object_buffer #(
    .DEPTH(DEPTH), .ENTRY_W(ENTRY_W), .ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_entry(in_entry),
    .in_nested(in_nested), .in_end_obj(in_end_obj), .in_offset(in_offset),
    .base_addr_in(base_addr_in), .base_addr_load(base_addr_load),
    .out_valid(out_valid), .out_ready(out_ready), .out_entry(out_entry),
    .out_base_addr(out_base_addr), .out_depth(out_depth), .count(count),
    .full(full), .empty(empty),
    .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every delivered entry is matched against the next expectation.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pop: got entry 0x%0h, expected no entry", out_entry);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_entry", 64'(out_entry), 64'(e.entry));
        check("out_base_addr", 64'(out_base_addr), 64'(e.base));
        check("out_depth", 64'(out_depth), 64'(e.depth));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic [ENTRY_W-1:0] ent, input logic [ADDR_W-1:0] b,
                            input logic [0:0] d);
    exp_t e;
    e.entry = ent;
    e.base  = b;
    e.depth = d;
    sb.push_back(e);
  endtask

  task automatic drive_in(input logic [ENTRY_W-1:0] ent, input logic nest, input logic endo,
                          input logic [ADDR_W-1:0] off);
    in_valid   = 1'b1;
    in_entry   = ent;
    in_nested  = nest;
    in_end_obj = endo;
    in_offset  = off;
  endtask

  task automatic push(input logic [ENTRY_W-1:0] ent, input logic nest, input logic endo,
                      input logic [ADDR_W-1:0] off, input logic [ADDR_W-1:0] b,
                      input logic [0:0] d);
    drive_in(ent, nest, endo, off);
    expect_out(ent, b, d);
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic load_base(input logic [ADDR_W-1:0] b);
    base_addr_in   = b;
    base_addr_load = 1'b1;
    cyc();
    base_addr_load = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (!empty && n < 40) begin
      cyc();
      n++;
    end
    out_ready = 1'b0;
    check("drain_empty", 64'(empty), 64'(1));
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_entry = '0;
    in_nested = 1'b0;
    in_end_obj = 1'b0;
    in_offset = '0;
    base_addr_in = '0;
    base_addr_load = 1'b0;
    out_ready = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    check("rst_empty", 64'(empty), 64'(1));
    check("rst_full", 64'(full), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_base", 64'(out_base_addr), 64'(0));
    check("rst_depth", 64'(out_depth), 64'(0));
    check("rst_count", 64'(count), 64'(0));
    check("rst_ovf", 64'(stack_overflow), 64'(0));
    check("rst_unf", 64'(stack_underflow), 64'(0));

    // Flat entries under root 0x1000
    load_base(32'h1000);
    check("load_base", 64'(out_base_addr), 64'(32'h1000));
    push(16'hA001, 0, 0, 0, 32'h1000, 0);
    push(16'hA002, 0, 0, 0, 32'h1000, 0);
    push(16'hA003, 0, 0, 0, 32'h1000, 0);
    check("flat_count", 64'(count), 64'(3));
    drain();

    // One nested object at +0x40; also fills the FIFO
    push(16'hB001, 1, 0, 32'h40, 32'h1000, 0);
    push(16'hB002, 0, 0, 0,      32'h1040, 1);
    push(16'hB003, 0, 1, 0,      32'h1040, 1);
    push(16'hB004, 0, 0, 0,      32'h1000, 0);
    check("full_flag", 64'(full), 64'(1));
    check("full_in_ready", 64'(in_ready), 64'(0));
    drive_in(16'hDEAD, 0, 0, 0);
    cyc();
    check("fifth_ignored", 64'(count), 64'(4));
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("full_pop_no_push", 64'(count), 64'(3));
    drain();
    check("nest_depth_back", 64'(out_depth), 64'(0));

    // Simultaneous push and pop at count=2
    push(16'hC001, 0, 0, 0, 32'h1000, 0);
    push(16'hC002, 0, 0, 0, 32'h1000, 0);
    drive_in(16'hC003, 0, 0, 0);
    expect_out(16'hC003, 32'h1000, 0);
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("pushpop_count", 64'(count), 64'(2));
    drain();

    // Streaming through the pointer wrap
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) push(16'hD000 + 16'(i), 0, 0, 0, 32'h1000, 0);
    drain();

    // Stack overflow with two slots, then underflow below the root
    push(16'hE001, 1, 0, 32'h10, 32'h1000, 0);
    push(16'hE002, 1, 1, 32'h20, 32'h1010, 1);
    push(16'hE003, 0, 0, 0,      32'h1010, 1);
    drain();
    check("ovf_flag", 64'(stack_overflow), 64'(1));
    check("ovf_depth", 64'(out_depth), 64'(1));
    check("ovf_no_unf", 64'(stack_underflow), 64'(0));
    push(16'hE004, 0, 1, 0, 32'h1010, 1);
    push(16'hE005, 0, 1, 0, 32'h1000, 0);
    drain();
    check("unf_flag", 64'(stack_underflow), 64'(1));
    check("unf_depth", 64'(out_depth), 64'(0));
    check("ovf_sticky", 64'(stack_overflow), 64'(1));

    // Base load wins over a same-cycle nested pop
    push(16'hF001, 1, 0, 32'h100, 32'h1000, 0);
    push(16'hF002, 0, 0, 0,       32'h2000, 0);
    out_ready = 1'b1;
    base_addr_in = 32'h2000;
    base_addr_load = 1'b1;
    cyc();
    out_ready = 1'b0;
    base_addr_load = 1'b0;
    check("load_pop_depth", 64'(out_depth), 64'(0));
    check("load_pop_base", 64'(out_base_addr), 64'(32'h2000));
    check("load_pop_count", 64'(count), 64'(1));
    drain();

    // Mid-stream reset discards entries and stack
    push(16'h9001, 1, 0, 32'h8, 32'h2000, 0);
    drain();
    check("pre_rst_depth", 64'(out_depth), 64'(1));
    drive_in(16'h9101, 0, 0, 0);
    cyc();
    drive_in(16'h9102, 0, 0, 0);
    cyc();
    drive_in(16'h9103, 0, 0, 0);
    cyc();
    in_valid = 1'b0;
    check("pre_rst_count", 64'(count), 64'(3));
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("mid_rst_empty", 64'(empty), 64'(1));
    check("mid_rst_depth", 64'(out_depth), 64'(0));
    check("mid_rst_count", 64'(count), 64'(0));
    check("mid_rst_base", 64'(out_base_addr), 64'(0));
    check("mid_rst_ovf", 64'(stack_overflow), 64'(0));

    cyc();
    check("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
